addsub_serial_16bit: RTL and testbench

Sequential, handshaked 16-bit signed saturating add/subtract unit. It is the responder on the same A/B/sub -> Sat_Sum/Ovfl interface that the 16-bit adder bench drives as initiator. It accepts one request, computes the result 4 bits per cycle through a single 4-bit carry-lookahead slice, then holds the saturated result until the consumer takes it. It targets the multi-cycle ALU path, where area matters more than latency.

---
 rtl/alu_pkg.sv | 17 +
 rtl/addsub_serial_16bit_if.sv | 29 ++
 rtl/cla_4bit.sv | 33 +++
 rtl/addsub_serial_16bit.sv | 112 +++++++++++
 tb/tb_addsub_serial_16bit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the serial saturating add/subtract unit.
// Holds the control-state encoding, default geometry and clamp values.
package alu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DEF_WIDTH-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DEF_WIDTH-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/addsub_serial_16bit_if.sv
// Request/response bundle between an add/sub initiator and responder.
// master drives operands and rsp_rdy; slave drives the result side.
interface addsub_serial_16bit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             req_vld;
    logic             req_rdy;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             rsp_vld;
    logic             rsp_rdy;
    logic [WIDTH-1:0] Sat_Sum;
    logic             Ovfl;

    modport master (
        output req_vld, A, B, sub, rsp_rdy,
        input  req_rdy, rsp_vld, Sat_Sum, Ovfl
    );

    modport slave (
        input  req_vld, A, B, sub, rsp_rdy,
        output req_rdy, rsp_vld, Sat_Sum, Ovfl
    );

endinterface

// File: rtl/cla_4bit.sv
// Combinational 4-bit carry-lookahead adder slice.
// All carries are flattened from generate/propagate terms.
module cla_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] S,
    output logic       cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign S    = w_p ^ w_c[3:0];
    assign cout = w_c[4];

endmodule

// File: rtl/addsub_serial_16bit.sv
// Handshaked signed saturating add/subtract, one 4-bit CLA slice per cycle.
// Result is registered on the last slice and held until rsp_rdy.
module addsub_serial_16bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input logic                 clk,
    input logic                 rst,
    addsub_serial_16bit_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_sat;
    logic             r_ovfl;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE-1:0] w_ss;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_accept;
    logic             w_last;

    assign w_accept = bus.req_vld && (r_state == IDLE);
    assign w_last   = (r_state == CALC)
                   && (r_cnt == CNT_W'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = CALC;
            CALC:    if (w_last)      w_state_nxt = DONE;
            DONE:    if (bus.rsp_rdy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_sa = r_a[int'(r_cnt)*SLICE +: SLICE];
    assign w_sb = r_b[int'(r_cnt)*SLICE +: SLICE];

    cla_4bit u_cla (
        .A    (w_sa),
        .B    (w_sb),
        .cin  (r_carry),
        .S    (w_ss),
        .cout (w_cout)
    );

    // Full sum including the slice being computed this cycle.
    always_comb begin
        w_sum = r_sum;
        w_sum[int'(r_cnt)*SLICE +: SLICE] = w_ss;
    end

    assign w_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
    assign w_res = w_ovf ? (r_a[MSB] ? SAT_NEG : SAT_POS) : w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_sat   <= '0;
            r_ovfl  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= bus.B ^ {WIDTH{bus.sub}};
            r_carry <= bus.sub;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (r_state == CALC) begin
            r_sum   <= w_sum;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sat  <= w_res;
                r_ovfl <= w_ovf;
            end
        end
    end

    assign bus.req_rdy = (r_state == IDLE);
    assign bus.rsp_vld = (r_state == DONE);
    assign bus.Sat_Sum = r_sat;
    assign bus.Ovfl    = r_ovfl;

endmodule

// File: tb/tb_addsub_serial_16bit.sv
// Bench for addsub_serial_16bit: vector table, handshake corner cases
// and a randomized run against an integer-arithmetic reference.
module tb_addsub_serial_16bit;
    import alu_pkg::*;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    addsub_serial_16bit_if #(.WIDTH(16)) bus ();

    addsub_serial_16bit #(.WIDTH(16), .SLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] exp_sum;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_model(input logic [15:0] a,
                                      input logic [15:0] b,
                                      input logic s,
                                      output logic [15:0] r,
                                      output logic o);
        int av;
        int bv;
        int x;
        av = int'($signed(a));
        bv = int'($signed(b));
        x  = s ? (av - bv) : (av + bv);
        if (x > 32767) begin
            r = SAT_POS;
            o = 1'b1;
        end else if (x < -32768) begin
            r = SAT_NEG;
            o = 1'b1;
        end else begin
            r = x[15:0];
            o = 1'b0;
        end
    endfunction

    // One full transaction starting and ending on a negedge.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                           input logic s, input int gap,
                           output logic [15:0] sum, output logic ovf,
                           output int lat, output bit hold_ok);
        int t;
        bus.A       = a;
        bus.B       = b;
        bus.sub     = s;
        bus.req_vld = 1'b1;
        bus.rsp_rdy = 1'b0;
        t = 0;
        while (!bus.req_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("accept_wait", 32'(t), 32'd0);
        @(negedge clk);
        bus.req_vld = 1'b0;
        bus.A       = 16'($urandom);
        bus.B       = 16'($urandom);
        bus.sub     = 1'($urandom);
        lat = 0;
        while (!bus.rsp_vld && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        sum     = bus.Sat_Sum;
        ovf     = bus.Ovfl;
        hold_ok = 1'b1;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (bus.Sat_Sum !== sum || bus.Ovfl !== ovf ||
                bus.rsp_vld !== 1'b1 || bus.req_rdy !== 1'b0)
                hold_ok = 1'b0;
        end
        bus.rsp_rdy = 1'b1;
        @(negedge clk);
        bus.rsp_rdy = 1'b0;
        if (bus.rsp_vld !== 1'b0 || bus.req_rdy !== 1'b1 ||
            bus.Sat_Sum !== sum || bus.Ovfl !== ovf)
            hold_ok = 1'b0;
    endtask

    vec_t        vecs[14];
    logic [15:0] got_sum;
    logic        got_ovf;
    int          lat;
    bit          hold_ok;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic [15:0] exp_sum;
    logic        exp_ovf;
    int          t;
    bit          ok;
    logic [15:0] corner[6];

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0};
        vecs[1]  = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1};
        vecs[4]  = '{16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0};
        vecs[8]  = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1};
        vecs[9]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[10] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1};
        vecs[11] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1};
        vecs[12] = '{16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b0};
        vecs[13] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};

        corner[0] = 16'h7FFF;
        corner[1] = 16'h8000;
        corner[2] = 16'h0000;
        corner[3] = 16'hFFFF;
        corner[4] = 16'h0001;
        corner[5] = 16'h7FFE;

        rst         = 1'b1;
        bus.req_vld = 1'b0;
        bus.rsp_rdy = 1'b0;
        bus.A       = 16'h0;
        bus.B       = 16'h0;
        bus.sub     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("reset_rsp_vld", 32'(bus.rsp_vld), 32'd0);
        check("reset_sum", 32'(bus.Sat_Sum), 32'd0);
        check("reset_ovfl", 32'(bus.Ovfl), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].s, i % 3,
                    got_sum, got_ovf, lat, hold_ok);
            check($sformatf("vec%0d_sum", i), 32'(got_sum),
                  32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_ovfl", i), 32'(got_ovf),
                  32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_hold", i), 32'(hold_ok), 32'd1);
        end

        // Backpressure with a second request pending.
        bus.A       = 16'h0005;
        bus.B       = 16'h0003;
        bus.sub     = 1'b0;
        bus.req_vld = 1'b1;
        t = 0;
        while (!bus.req_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        bus.A = 16'h1111;
        t = 0;
        while (!bus.rsp_vld && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_latency", 32'(t), 32'd4);
        check("bp_sum", 32'(bus.Sat_Sum), 32'h0008);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.Sat_Sum !== 16'h0008 || bus.req_rdy !== 1'b0 ||
                bus.rsp_vld !== 1'b1)
                ok = 1'b0;
        end
        check("bp_hold", 32'(ok), 32'd1);
        bus.rsp_rdy = 1'b1;
        @(negedge clk);
        bus.rsp_rdy = 1'b0;
        check("bp_no_turnaround", 32'(bus.req_rdy), 32'd1);
        @(negedge clk);
        check("bp_second_accept", 32'(bus.req_rdy), 32'd0);
        bus.req_vld = 1'b0;
        t = 0;
        while (!bus.rsp_vld && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp2_latency", 32'(t), 32'd4);
        check("bp2_sum", 32'(bus.Sat_Sum), 32'h1114);
        bus.rsp_rdy = 1'b1;
        @(negedge clk);
        bus.rsp_rdy = 1'b0;

        // Reset pulse on the second CALC cycle.
        bus.A       = 16'h1234;
        bus.B       = 16'h1111;
        bus.req_vld = 1'b1;
        t = 0;
        while (!bus.req_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        bus.req_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
        check("rst_sum", 32'(bus.Sat_Sum), 32'd0);
        check("rst_ovfl", 32'(bus.Ovfl), 32'd0);
        bus.rsp_rdy = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_vld !== 1'b0) ok = 1'b0;
        end
        bus.rsp_rdy = 1'b0;
        check("rst_no_response", 32'(ok), 32'd1);

        // Randomized regression against the integer reference.
        for (int n = 0; n < 200; n++) begin
            ra = ($urandom_range(0, 3) == 0) ?
                 corner[$urandom_range(0, 5)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ?
                 corner[$urandom_range(0, 5)] : 16'($urandom);
            rs = 1'($urandom);
            ref_model(ra, rb, rs, exp_sum, exp_ovf);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(ra, rb, rs, $urandom_range(0, 3),
                    got_sum, got_ovf, lat, hold_ok);
            check($sformatf("rnd%0d_sum a=%h b=%h s=%0d", n, ra, rb, rs),
                  32'(got_sum), 32'(exp_sum));
            check($sformatf("rnd%0d_ovfl", n), 32'(got_ovf),
                  32'(exp_ovf));
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd4);
            check($sformatf("rnd%0d_hold", n), 32'(hold_ok), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
